// File: rtl/symm_mac_acc.sv
// symm_mac_acc: streaming engine computing Y = alpha*sum(A*B) + beta*C over VEC_LEN beats.
// Optional macro SYMM_MAC_SAT_EN: clamp accumulator and results instead of wrapping, with a sticky sat_flag.
module symm_mac_acc #(
  parameter int DATA_W  = 32,
  parameter int COEF_W  = 16,
  parameter int ACC_W   = 64,
  parameter int VEC_LEN = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [COEF_W-1:0] alpha,
  input  logic signed [COEF_W-1:0] beta,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic signed [DATA_W-1:0] c_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  y_ab,
  output logic signed [ACC_W-1:0]  y_c,
  output logic signed [ACC_W-1:0]  y_out,
  output logic                     busy,
  output logic                     sat_flag
);

  localparam int PROD_W = 2 * DATA_W;
  // Wide enough to hold alpha*acc + beta*C exactly, so overflow is detected before truncation.
  localparam int FULL_W = ACC_W + COEF_W + 1;
  localparam logic [15:0] LAST_BEAT = 16'(VEC_LEN - 1);
`ifdef SYMM_MAC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCALE = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                     state_r;
  logic signed [ACC_W-1:0]    acc_r;
  logic [15:0]                cnt_r;
  logic signed [DATA_W-1:0]   c_r;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [FULL_W-1:0]   acc_sum_s;
  logic signed [FULL_W-1:0]   ab_full_s;
  logic signed [FULL_W-1:0]   c_full_s;
  logic signed [FULL_W-1:0]   y_full_s;

  function automatic logic ovf_fn(input logic [FULL_W-1:0] v);
    return !((&v[FULL_W-1:ACC_W-1]) || !(|v[FULL_W-1:ACC_W-1]));
  endfunction

  function automatic logic [ACC_W-1:0] fit_fn(input logic [FULL_W-1:0] v);
    logic [ACC_W-1:0] r;
    if (SAT_EN && ovf_fn(v)) begin
      r = v[FULL_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r = v[ACC_W-1:0];
    end
    return r;
  endfunction

  // Exact-width datapath for the accumulate and scale steps.
  always_comb begin
    prod_s    = PROD_W'(a_in) * PROD_W'(b_in);
    acc_sum_s = FULL_W'(acc_r) + FULL_W'(prod_s);
    ab_full_s = FULL_W'(alpha) * FULL_W'(acc_r);
    c_full_s  = FULL_W'(beta) * FULL_W'(c_r);
    y_full_s  = ab_full_s + c_full_s;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_ACCUM;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= 16'd0;
      c_r       <= {DATA_W{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_ab      <= {ACC_W{1'b0}};
      y_c       <= {ACC_W{1'b0}};
      y_out     <= {ACC_W{1'b0}};
      busy      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (in_valid && in_ready) begin
            acc_r    <= fit_fn(acc_sum_s);
            sat_flag <= sat_flag | (SAT_EN & ovf_fn(acc_sum_s));
            if (cnt_r == LAST_BEAT) begin
              cnt_r    <= 16'd0;
              c_r      <= c_in;
              state_r  <= ST_SCALE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
        end
        ST_SCALE: begin
          y_ab      <= fit_fn(ab_full_s);
          y_c       <= fit_fn(c_full_s);
          y_out     <= fit_fn(y_full_s);
          sat_flag  <= sat_flag | (SAT_EN & (ovf_fn(ab_full_s) | ovf_fn(c_full_s) | ovf_fn(y_full_s)));
          out_valid <= 1'b1;
          state_r   <= ST_OUT;
        end
        ST_OUT: begin
          // in_ready only returns after the handshake, so vectors never overlap.
          if (out_valid && out_ready) begin
            acc_r     <= {ACC_W{1'b0}};
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_ACCUM;
          end
        end
        default: begin
          state_r   <= ST_ACCUM;
          acc_r     <= {ACC_W{1'b0}};
          cnt_r     <= 16'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
